// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory arbiter: FSM encoding and wait-time default.
// No logic here; latency and backpressure are defined by mem_arbiter.
package cpu_mem_pkg;

  localparam int WAIT_CYCLES_DEF = 2;
  localparam int WAIT_CNT_W      = 4;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_IACC = 2'd1;
  localparam arb_state_t ST_DACC = 2'd2;
  localparam arb_state_t ST_DONE = 2'd3;

  // Data wins when it is the only requester, or when both ask and the pointer favours data.
  function automatic logic grant_data(input logic i_req, input logic d_req, input logic prio_d);
    return d_req && (!i_req || prio_d);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction/data requester ports and the shared memory port.
// master = requesters and memory model side, slave = the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_read;
  logic              m_write;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, m_addr, m_wdata, m_read, m_write
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, m_addr, m_wdata, m_read, m_write
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Down-counter timing the memory access phase; done flags the last access cycle.
// Load has priority over counting; no backpressure.
module mem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of instruction and data requesters onto one memory port (optional ARB_STATS_EN stats).
// Latency: req in IDLE at N -> access N+1..N+WAIT_CYCLES -> ack at N+WAIT_CYCLES+1; requests wait while busy.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_arbiter_if.slave       bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]        stat_conflicts
`endif
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              prio_d_q;
  logic              gnt_d_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic in_idle;
  logic in_acc;
  logic any_req;
  logic pick_d;
  logic grant;
  logic wait_done;

  assign in_idle = (state_q == ST_IDLE);
  assign in_acc  = (state_q == ST_IACC) || (state_q == ST_DACC);
  assign any_req = bus.i_req || bus.d_req;
  assign pick_d  = grant_data(bus.i_req, bus.d_req, prio_d_q);
  assign grant   = in_idle && any_req;

  mem_wait_counter #(
    .CNT_W(WAIT_CNT_W)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (grant),
    .load_val (WAIT_CNT_W'(WAIT_CYCLES)),
    .en       (in_acc),
    .done     (wait_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = pick_d ? ST_DACC : ST_IACC;
        end
      end
      ST_IACC, ST_DACC: begin
        if (wait_done) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      prio_d_q  <= 1'b1;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // Requester inputs are captured once here and ignored until the next IDLE.
      if (grant) begin
        gnt_d_q <= pick_d;
        we_q    <= pick_d && bus.d_we;
        addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
        wdata_q <= pick_d ? bus.d_wdata : '0;
      end
      if (wait_done && !we_q) begin
        if (gnt_d_q) begin
          d_rdata_q <= bus.m_rdata;
        end else begin
          i_rdata_q <= bus.m_rdata;
        end
      end
      if (state_q == ST_DONE) begin
        prio_d_q <= !gnt_d_q;
      end
    end
  end

  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_read  = in_acc && !we_q;
  assign bus.m_write = in_acc && we_q;
  assign bus.i_ack   = (state_q == ST_DONE) && !gnt_d_q;
  assign bus.d_ack   = (state_q == ST_DONE) && gnt_d_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] conflicts_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflicts_q <= '0;
    end else if (in_idle && bus.i_req && bus.d_req && (conflicts_q != 16'hFFFF)) begin
      conflicts_q <= conflicts_q + 16'd1;
    end
  end

  assign stat_conflicts = conflicts_q;
`endif

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst) !(bus.m_read && bus.m_write));

endmodule
